// File: rtl/bip_pkg.sv
// Shared widths, opcodes and decoder control encodings for the BIP accumulator processor.
package bip_pkg;

  localparam int PC_W   = 11;
  localparam int DATA_W = 16;
  localparam int OPC_W  = 5;
  localparam int CNT_W  = 32;

  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    SEL_A_RAM  = 2'b00,
    SEL_A_IMM  = 2'b01,
    SEL_A_ALU  = 2'b10,
    SEL_A_NONE = 2'b11
  } selA_e;

  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;
  localparam logic OP_ADD    = 1'b1;
  localparam logic OP_SUB    = 1'b0;

endpackage

// File: rtl/bip_alu.sv
// Combinational add/subtract unit; results wrap modulo 2^DATA_W, no flags.
module bip_alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W-1:0] result
);

  assign result = op ? (a + b) : (a - b);

endmodule

// File: rtl/bip_datapath.sv
// BIP execution datapath: PC, accumulator, run-cycle counter and memory interface,
// steered by the instruction decoder's control outputs; one instruction per run cycle.
module bip_datapath #(
  parameter int PC_W   = bip_pkg::PC_W,
  parameter int DATA_W = bip_pkg::DATA_W,
  parameter int OPC_W  = bip_pkg::OPC_W,
  parameter int CNT_W  = bip_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_instruction,
  input  logic              i_wr_pc,
  input  logic [1:0]        i_sel_a,
  input  logic              i_sel_b,
  input  logic              i_wr_acc,
  input  logic              i_op,
  input  logic              i_wr_ram,
  input  logic              i_rd_ram,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [OPC_W-1:0]  o_opcode,
  output logic [PC_W-1:0]   o_pc,
  output logic [PC_W-1:0]   o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  output logic              o_ram_re,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_cycles
);

  import bip_pkg::*;

  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] accNext;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] aluB;
  logic [DATA_W-1:0] aluResult;
  logic [CNT_W-1:0]  cycles;
  logic              halted;
  logic              run;
  selA_e             selA;

  assign run  = i_enable & ~halted;
  assign selA = selA_e'(i_sel_a);

  // The operand field doubles as data address and as a signed immediate.
  assign imm  = {{(DATA_W-PC_W){i_instruction[PC_W-1]}}, i_instruction[PC_W-1:0]};
  assign aluB = (i_sel_b == SEL_B_IMM) ? imm : i_ram_rdata;

  bip_alu #(.DATA_W(DATA_W)) uAlu (
    .a      (acc),
    .b      (aluB),
    .op     (i_op),
    .result (aluResult)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives accNext and no latch is inferred.
    accNext = acc;
    case (selA)
      SEL_A_RAM: accNext = i_ram_rdata;
      SEL_A_IMM: accNext = imm;
      SEL_A_ALU: accNext = aluResult;
      default:   accNext = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      acc    <= '0;
      halted <= 1'b0;
      cycles <= '0;
    end else if (run) begin
      // NOTE: non-blocking so every register samples pre-edge values (STO writes the old ACC).
      if (i_wr_acc) acc <= accNext;
      if (i_wr_pc)  pc  <= pc + PC_W'(1);
      else          halted <= 1'b1;
      if (cycles != '1) cycles <= cycles + CNT_W'(1);
    end
  end

  assign o_opcode    = i_instruction[DATA_W-1 -: OPC_W];
  assign o_ram_addr  = i_instruction[PC_W-1:0];
  assign o_pc        = pc;
  assign o_acc       = acc;
  assign o_ram_wdata = acc;
  assign o_ram_we    = run & i_wr_ram;
  assign o_ram_re    = run & i_rd_ram;
  assign o_halted    = halted;
  assign o_cycles    = cycles;

endmodule

// File: tb/tb_bip_datapath.sv
// Directed bench for bip_datapath: a vector table for the main program flow plus
// hand-written sequences for reset, halt, accumulator hold and PC wrap.
module tb_bip_datapath;
  import bip_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] instruction;
  logic        wrPc;
  logic [1:0]  selA;
  logic        selB;
  logic        wrAcc;
  logic        op;
  logic        wrRam;
  logic        rdRam;
  logic [15:0] ramRdata;
  logic [4:0]  opcode;
  logic [10:0] pc;
  logic [10:0] ramAddr;
  logic [15:0] ramWdata;
  logic        ramWe;
  logic        ramRe;
  logic [15:0] acc;
  logic        halted;
  logic [31:0] cycles;

  int passCount = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  bip_datapath dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (enable),
    .i_instruction (instruction),
    .i_wr_pc       (wrPc),
    .i_sel_a       (selA),
    .i_sel_b       (selB),
    .i_wr_acc      (wrAcc),
    .i_op          (op),
    .i_wr_ram      (wrRam),
    .i_rd_ram      (rdRam),
    .i_ram_rdata   (ramRdata),
    .o_opcode      (opcode),
    .o_pc          (pc),
    .o_ram_addr    (ramAddr),
    .o_ram_wdata   (ramWdata),
    .o_ram_we      (ramWe),
    .o_ram_re      (ramRe),
    .o_acc         (acc),
    .o_halted      (halted),
    .o_cycles      (cycles)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] rdata;
    logic        en;
    logic        expWe;
    logic        expRe;
    logic [15:0] expWdata;
    logic [15:0] expAcc;
    logic [10:0] expPc;
    logic [31:0] expCyc;
    logic        expHalt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passCount++;
  endtask

  // Decoder model: drives the control lines the real decoder would produce for an opcode.
  task automatic drive(input logic [15:0] instr, input logic [15:0] rdata, input logic en);
    logic [4:0] opc;
    opc = instr[15:11];
    instruction = instr;
    ramRdata    = rdata;
    enable      = en;
    wrPc = 1'b1; selA = SEL_A_NONE; selB = SEL_B_RAM; wrAcc = 1'b0;
    op = OP_ADD; wrRam = 1'b0; rdRam = 1'b0;
    case (opc)
      OPC_HALT: wrPc = 1'b0;
      OPC_STO:  wrRam = 1'b1;
      OPC_LD:   begin selA = SEL_A_RAM; wrAcc = 1'b1; rdRam = 1'b1; end
      OPC_LDI:  begin selA = SEL_A_IMM; wrAcc = 1'b1; end
      OPC_ADD:  begin selA = SEL_A_ALU; wrAcc = 1'b1; rdRam = 1'b1; end
      OPC_ADDI: begin selA = SEL_A_ALU; selB = SEL_B_IMM; wrAcc = 1'b1; end
      OPC_SUB:  begin selA = SEL_A_ALU; op = OP_SUB; wrAcc = 1'b1; rdRam = 1'b1; end
      OPC_SUBI: begin selA = SEL_A_ALU; selB = SEL_B_IMM; op = OP_SUB; wrAcc = 1'b1; end
      default:  wrPc = 1'b0;
    endcase
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    enable = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[13];

  initial begin
    rst_n = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    vecs[0]  = '{16'h1FFB, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFB, 11'd1, 32'd1, 1'b0};
    vecs[1]  = '{16'h2807, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFFFB, 16'h0002, 11'd2, 32'd2, 1'b0};
    vecs[2]  = '{16'h3010, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0002, 16'hFFFF, 11'd3, 32'd3, 1'b0};
    vecs[3]  = '{16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h03FF, 11'd4, 32'd4, 1'b0};
    vecs[4]  = '{16'h1000, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h03FF, 16'h1234, 11'd5, 32'd5, 1'b0};
    vecs[5]  = '{16'h0820, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h1234, 11'd6, 32'd6, 1'b0};
    vecs[6]  = '{16'h2807, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1234, 11'd6, 32'd6, 1'b0};
    vecs[7]  = '{16'h0820, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1234, 11'd6, 32'd6, 1'b0};
    vecs[8]  = '{16'h1000, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1234, 11'd6, 32'd6, 1'b0};
    vecs[9]  = '{16'h2001, 16'h0010, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h1244, 11'd7, 32'd7, 1'b0};
    vecs[10] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1244, 16'h1244, 11'd7, 32'd8, 1'b1};
    vecs[11] = '{16'h0820, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1244, 16'h1244, 11'd7, 32'd8, 1'b1};
    vecs[12] = '{16'h2807, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1244, 16'h1244, 11'd7, 32'd8, 1'b1};

    check("reset_pc", 32'(pc), 32'd0);
    check("reset_acc", 32'(acc), 32'd0);
    check("reset_cycles", cycles, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);

    for (int i = 0; i < 13; i++) begin
      logic [15:0] ins;
      ins = vecs[i].instr;
      drive(ins, vecs[i].rdata, vecs[i].en);
      check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(ins[15:11]));
      check($sformatf("v%0d_addr", i), 32'(ramAddr), 32'(ins[10:0]));
      check($sformatf("v%0d_we", i), 32'(ramWe), 32'(vecs[i].expWe));
      check($sformatf("v%0d_re", i), 32'(ramRe), 32'(vecs[i].expRe));
      check($sformatf("v%0d_wdata", i), 32'(ramWdata), 32'(vecs[i].expWdata));
      tick();
      check($sformatf("v%0d_acc", i), 32'(acc), 32'(vecs[i].expAcc));
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].expPc));
      check($sformatf("v%0d_cycles", i), cycles, vecs[i].expCyc);
      check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].expHalt));
    end

    // Asynchronous reset mid-cycle while halted: state clears before any edge.
    drive(16'h0820, 16'h0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_acc", 32'(acc), 32'd0);
    check("async_rst_halted", 32'(halted), 32'd0);
    check("async_rst_cycles", cycles, 32'd0);
    check("async_rst_we", 32'(ramWe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four instructions, then HALT: PC frozen at 4, five run cycles counted.
    for (int i = 0; i < 4; i++) begin
      drive(16'h2801, 16'h0000, 1'b1);
      tick();
    end
    drive(16'h0000, 16'h0000, 1'b1);
    tick();
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'd4);
    check("halt_cycles", cycles, 32'd5);
    check("halt_acc", 32'(acc), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(16'h2807, 16'h0000, logic'(i % 2));
      tick();
    end
    drive(16'h1000, 16'h0077, 1'b1);
    check("halted_re", 32'(ramRe), 32'd0);
    tick();
    check("halted_sticky", 32'(halted), 32'd1);
    check("halted_pc", 32'(pc), 32'd4);
    check("halted_acc", 32'(acc), 32'd4);
    check("halted_cycles", cycles, 32'd5);

    // Illegal opcode also halts.
    doReset();
    drive(16'hF800, 16'h0000, 1'b1);
    tick();
    check("illegal_halt", 32'(halted), 32'd1);
    check("illegal_pc", 32'(pc), 32'd0);
    check("illegal_cycles", cycles, 32'd1);

    // sel_a = NONE holds ACC even with wr_acc asserted.
    doReset();
    drive(16'h1805, 16'h0000, 1'b1);
    tick();
    check("ldi5_acc", 32'(acc), 32'd5);
    drive(16'h2807, 16'h0099, 1'b1);
    selA = SEL_A_NONE;
    wrAcc = 1'b1;
    #1;
    tick();
    check("selnone_acc", 32'(acc), 32'd5);
    check("selnone_pc", 32'(pc), 32'd2);

    // PC wrap after 2047 ADDI 0.
    doReset();
    drive(16'h2800, 16'h0000, 1'b1);
    for (int i = 0; i < 2047; i++) tick();
    check("prewrap_pc", 32'(pc), 32'd2047);
    check("prewrap_acc", 32'(acc), 32'd0);
    tick();
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_acc", 32'(acc), 32'd0);
    check("wrap_cycles", cycles, 32'd2048);
    check("wrap_halted", 32'(halted), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
